ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_arb_pkg.sv | 27 ++
 rtl/rr_priority_picker.sv | 49 ++++
 rtl/ram_port_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
// Shared definitions for the single-port RAM arbiter:
//   - default RAM geometry and requester count,
//   - arbiter state encoding,
//   - fixed requester IDs used by the surrounding system.
// ---------------------------------------------------------------------------
package ram_arb_pkg;

    // Default RAM geometry
    localparam int DATA_W_DEF    = 32;
    localparam int RAM_D_DEF     = 512;
    localparam int N_REQ_DEF     = 3;
    localparam int MAX_BURST_DEF = 16;

    // Requester IDs (bit position in req/gnt/rvalid)
    localparam int REQ_HOST_LOAD = 0;
    localparam int REQ_MATMUL    = 1;
    localparam int REQ_HOST_READ = 2;

    // Arbiter state: nobody owns the port, or exactly one requester does
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

endpackage : ram_arb_pkg

// File: rtl/rr_priority_picker.sv
// ---------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin picker. The search starts at (last_owner+1) and
// wraps modulo N_REQ; the first requester with its req bit set wins.
//
// Ports:
//   req        [N_REQ-1:0]  candidate request vector
//   last_owner [IDX_W-1:0]  index of the most recent owner
//   winner     [N_REQ-1:0]  one-hot winner (all zero if no request)
//   valid                   at least one candidate was requesting
// ---------------------------------------------------------------------------
module rr_priority_picker #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_owner,
    output logic [N_REQ-1:0] winner,
    output logic             valid
);

    logic [N_REQ-1:0] above_mask_s;
    logic [N_REQ-1:0] upper_req_s;
    logic [N_REQ-1:0] cand_s;

    // Requesters strictly above last_owner are searched first; if none of
    // them is requesting, the search wraps to the bottom of the vector.
    always_comb begin
        above_mask_s = {N_REQ{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            above_mask_s[i] = (i > int'(last_owner)) ? 1'b1 : 1'b0;
        end
        upper_req_s = req & above_mask_s;
        cand_s      = (|upper_req_s) ? upper_req_s : req;
    end

    // Lowest set bit of the candidate vector becomes the one-hot winner
    always_comb begin
        logic taken;
        taken  = 1'b0;
        winner = {N_REQ{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            winner[i] = cand_s[i] & ~taken;
            taken     = taken | cand_s[i];
        end
        valid = |req;
    end

endmodule : rr_priority_picker

// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
// Shares one synchronous single-port RAM between N_REQ requesters using
// round-robin arbitration with a burst limit. An owner keeps the port as long
// as it holds req; after MAX_BURST accepted accesses it yields if anybody else
// is waiting, otherwise its burst counter restarts and it keeps the grant.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req/req_we [N_REQ]       per-requester request level and write enable
//   req_addr  [N_REQ*ADDR_W] packed addresses, requester i in slice i
//   req_wdata [N_REQ*DATA_W] packed write data, requester i in slice i
//   gnt       [N_REQ]        registered one-hot-or-zero grant
//   rvalid    [N_REQ]        read-data strobe, one cycle after accepted read
//   rdata     [DATA_W]       read data (pass-through of ram_r_data)
//   ram_we/ram_addr/ram_w_data  RAM command, muxed from the owner only
//   ram_r_data [DATA_W]      RAM read data, one-cycle latency
//   busy                     any grant active
// ---------------------------------------------------------------------------
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RAM_D     = RAM_D_DEF,
    parameter int ADDR_W    = $clog2(RAM_D),
    parameter int N_REQ     = N_REQ_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         req_we,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_wdata,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic                     ram_we,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [DATA_W-1:0]        ram_w_data,
    input  logic [DATA_W-1:0]        ram_r_data,
    output logic                     busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // State and registered outputs
    arb_state_e          state_r,      state_s;
    logic [N_REQ-1:0]    gnt_r,        gnt_s;
    logic [IDX_W-1:0]    owner_r,      owner_s;
    logic [IDX_W-1:0]    last_owner_r, last_owner_s;
    logic [CNT_W-1:0]    count_r,      count_s;
    logic [N_REQ-1:0]    rvalid_r,     rvalid_s;

    // Decision helpers
    logic                accept_s;
    logic                others_s;
    logic                release_s;
    logic [CNT_W-1:0]    cnt_inc_s;

    // Picker interface
    logic [N_REQ-1:0]    pick_req_s;
    logic [IDX_W-1:0]    pick_last_s;
    logic [N_REQ-1:0]    win_onehot_s;
    logic                win_valid_s;
    logic [IDX_W-1:0]    win_idx_s;

    // Owner access acceptance and pending-competitor detection
    always_comb begin
        accept_s  = (state_r == ST_OWNED) && (|(gnt_r & req));
        others_s  = |(req & ~gnt_r);
        cnt_inc_s = count_r + CNT_ONE;
    end

    // Picker inputs: while owned, the current owner is excluded and the search
    // starts after it, so a hand-over never re-selects the yielding owner.
    always_comb begin
        if (state_r == ST_OWNED) begin
            pick_req_s  = req & ~gnt_r;
            pick_last_s = owner_r;
        end else begin
            pick_req_s  = req;
            pick_last_s = last_owner_r;
        end
    end

    rr_priority_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req        (pick_req_s),
        .last_owner (pick_last_s),
        .winner     (win_onehot_s),
        .valid      (win_valid_s)
    );

    // One-hot winner to binary index
    always_comb begin
        win_idx_s = {IDX_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            win_idx_s = win_idx_s | (win_onehot_s[i] ? IDX_W'(i) : {IDX_W{1'b0}});
        end
    end

    // Next-state: arbitration, burst counting, release and hand-over
    always_comb begin
        state_s      = state_r;
        gnt_s        = gnt_r;
        owner_s      = owner_r;
        last_owner_s = last_owner_r;
        count_s      = count_r;
        rvalid_s     = {N_REQ{1'b0}};
        release_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                count_s = {CNT_W{1'b0}};
                if (win_valid_s) begin
                    state_s = ST_OWNED;
                    gnt_s   = win_onehot_s;
                    owner_s = win_idx_s;
                end else begin
                    gnt_s   = {N_REQ{1'b0}};
                end
            end
            ST_OWNED: begin
                // gnt_r is the owner's one-hot, so this strobes only the owner
                rvalid_s = accept_s ? (gnt_r & ~req_we) : {N_REQ{1'b0}};
                if (!accept_s) begin
                    // Owner dropped req (including the cycle its grant rose)
                    release_s = 1'b1;
                end else if (cnt_inc_s == CNT_MAX) begin
                    // This access completes the burst: yield only if contested
                    count_s   = {CNT_W{1'b0}};
                    release_s = others_s;
                end else begin
                    count_s   = cnt_inc_s;
                end
                if (release_s) begin
                    last_owner_s = owner_r;
                    count_s      = {CNT_W{1'b0}};
                    if (win_valid_s) begin
                        gnt_s   = win_onehot_s;
                        owner_s = win_idx_s;
                    end else begin
                        state_s = ST_IDLE;
                        gnt_s   = {N_REQ{1'b0}};
                    end
                end else begin
                    gnt_s = gnt_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                gnt_s   = {N_REQ{1'b0}};
                count_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            gnt_r        <= {N_REQ{1'b0}};
            owner_r      <= {IDX_W{1'b0}};
            last_owner_r <= LAST_RST;
            count_r      <= {CNT_W{1'b0}};
            rvalid_r     <= {N_REQ{1'b0}};
        end else begin
            state_r      <= state_s;
            gnt_r        <= gnt_s;
            owner_r      <= owner_s;
            last_owner_r <= last_owner_s;
            count_r      <= count_s;
            rvalid_r     <= rvalid_s;
        end
    end

    // RAM command mux: AND-OR on the grant vector, so only the owner's slices
    // can reach the RAM and everything is zero while idle.
    always_comb begin
        ram_we     = |(gnt_r & req & req_we);
        ram_addr   = {ADDR_W{1'b0}};
        ram_w_data = {DATA_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            ram_addr   = ram_addr   | (gnt_r[i] ? req_addr[i*ADDR_W +: ADDR_W]
                                                : {ADDR_W{1'b0}});
            ram_w_data = ram_w_data | (gnt_r[i] ? req_wdata[i*DATA_W +: DATA_W]
                                                : {DATA_W{1'b0}});
        end
    end

    // Output drive
    always_comb begin
        gnt    = gnt_r;
        rvalid = rvalid_r;
        busy   = |gnt_r;
        rdata  = ram_r_data;
    end

endmodule : ram_port_arbiter

// File: tb/tb_ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_port_arbiter
// Directed scenarios followed by randomized traffic. A behavioural model
// (owner index, last owner, burst count, shadow memory) predicts grants and
// RAM commands each cycle and pushes expected read responses into a queue;
// the monitor pops that queue whenever rvalid is presented.
// ---------------------------------------------------------------------------
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    localparam int N      = 3;
    localparam int DW     = 32;
    localparam int RD     = 512;
    localparam int AW     = 9;
    localparam int MAXB   = 16;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req;
    logic [N-1:0]      req_we;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      gnt;
    logic [N-1:0]      rvalid;
    logic [DW-1:0]     rdata;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_w_data;
    logic [DW-1:0]     ram_r_data;
    logic              busy;

    ram_port_arbiter #(
        .DATA_W(DW), .RAM_D(RD), .ADDR_W(AW), .N_REQ(N), .MAX_BURST(MAXB)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_w_data(ram_w_data),
        .ram_r_data(ram_r_data), .busy(busy)
    );

    typedef struct {
        int          id;
        logic [31:0] data;
    } exp_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          phase = 0;
    int          acc0_base = 0;
    int          acc_cnt [N];
    logic [31:0] last_rd2;
    exp_t        exp_q [$];
    logic [31:0] mem    [RD];
    logic [31:0] shadow [RD];
    int          m_owner, m_last, m_cnt;

    function automatic logic [31:0] init_word(input int i);
        if (i == 5) return 32'hDEADBEEF;
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A5A5A;
    endfunction

    // Round-robin: first requester after 'last', wrapping; -1 if none
    function automatic int pick(input logic [N-1:0] r, input int last);
        int idx;
        for (int k = 1; k <= N; k++) begin
            idx = (last + k) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Model advance using the inputs the DUT will sample on the next edge
    task automatic model_step();
        logic [AW-1:0] a;
        logic [N-1:0]  others;
        if (m_owner < 0) begin
            m_owner = pick(req, m_last);
            m_cnt   = 0;
        end else if (!req[m_owner]) begin
            m_last  = m_owner;
            m_owner = pick(req, m_last);
            m_cnt   = 0;
        end else begin
            a = req_addr[m_owner*AW +: AW];
            if (req_we[m_owner]) shadow[a] = req_wdata[m_owner*DW +: DW];
            else exp_q.push_back('{m_owner, shadow[a]});
            m_cnt++;
            if (m_cnt == MAXB) begin
                m_cnt  = 0;
                others = req;
                others[m_owner] = 1'b0;
                if (others != '0) begin
                    m_last  = m_owner;
                    m_owner = pick(others, m_last);
                end
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous RAM with one-cycle read latency
    initial begin
        for (int i = 0; i < RD; i++) mem[i] = init_word(i);
        ram_r_data = 32'h0;
        forever begin
            @(posedge clk);
            if (ram_we) mem[ram_addr] <= ram_w_data;
            ram_r_data <= mem[ram_addr];
        end
    end

    // Monitor: scoreboard pops on rvalid, per-cycle grant/RAM checks, model
    initial begin
        exp_t          e;
        logic [N-1:0]  exp_gnt;
        logic [N-1:0]  exp_rv;
        for (int i = 0; i < RD; i++) shadow[i] = init_word(i);
        for (int i = 0; i < N; i++) acc_cnt[i] = 0;
        last_rd2 = 32'h0;
        m_owner = -1; m_last = N - 1; m_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("rst_gnt",    64'(gnt),      64'd0);
                check("rst_rvalid", 64'(rvalid),   64'd0);
                check("rst_busy",   64'(busy),     64'd0);
                check("rst_ram_we", 64'(ram_we),   64'd0);
                check("rst_addr",   64'(ram_addr), 64'd0);
                exp_q.delete();
                m_owner = -1; m_last = N - 1; m_cnt = 0;
            end else begin
                for (int i = 0; i < N; i++) if (gnt[i] && req[i]) acc_cnt[i]++;
                if (rvalid != '0) begin
                    if (exp_q.size() == 0) begin
                        check("rvalid_unexpected", 64'(rvalid), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        exp_rv = '0;
                        exp_rv[e.id] = 1'b1;
                        check("rvalid_id", 64'(rvalid), 64'(exp_rv));
                        check("rdata",     64'(rdata),  64'(e.data));
                        if (e.id == REQ_HOST_READ) last_rd2 = rdata;
                    end
                end else if (exp_q.size() != 0) begin
                    check("rvalid_missing", 64'(rvalid), 64'(1) << exp_q[0].id);
                    exp_q.delete();
                end
                exp_gnt = '0;
                if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
                check("gnt",  64'(gnt),  64'(exp_gnt));
                check("busy", 64'(busy), 64'(m_owner >= 0));
                if (m_owner >= 0) begin
                    check("ram_we",   64'(ram_we),
                          64'(req[m_owner] & req_we[m_owner]));
                    check("ram_addr", 64'(ram_addr),   64'(req_addr[m_owner*AW +: AW]));
                    check("ram_wdat", 64'(ram_w_data), 64'(req_wdata[m_owner*DW +: DW]));
                end else begin
                    check("idle_we",   64'(ram_we),     64'd0);
                    check("idle_addr", 64'(ram_addr),   64'd0);
                    check("idle_wdat", 64'(ram_w_data), 64'd0);
                end
                if (phase == 1) check("burst_len0", 64'(acc_cnt[0] - acc0_base), 64'd16);
                if (phase == 2) check("rd511_data", 64'(last_rd2), 64'h12345678);
                if (phase == 3) check("queue_empty", 64'(exp_q.size()), 64'd0);
                model_step();
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_req(input int i, input logic on, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]                = on;
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_all();
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_all();
        tick(2);
        rst = 1'b1;
    endtask

    // Stimulus
    initial begin
        rst = 1'b0;
        clear_all();
        tick(3);
        // Single reader of address 5
        rst = 1'b1;
        set_req(REQ_MATMUL, 1'b1, 1'b0, 9'd5, 32'h0);
        tick(3);
        clear_all();
        tick(3);
        // Simultaneous 0 and 2 after reset: 0 first, then 2 without a bubble
        do_reset();
        set_req(REQ_HOST_LOAD, 1'b1, 1'b0, 9'd1, 32'h0);
        set_req(REQ_HOST_READ, 1'b1, 1'b0, 9'd2, 32'h0);
        tick(5);
        set_req(REQ_HOST_LOAD, 1'b0, 1'b0, 9'd0, 32'h0);
        tick(4);
        clear_all();
        tick(3);
        // Burst limit with a waiting requester
        do_reset();
        acc0_base = acc_cnt[0];
        set_req(REQ_HOST_LOAD, 1'b1, 1'b0, 9'd3, 32'h0);
        set_req(REQ_MATMUL,    1'b1, 1'b1, 9'd4, 32'hA5A5_0001);
        for (int c = 0; c < 40; c++) begin
            phase = (c == 24) ? 1 : 0;
            set_req(REQ_HOST_LOAD, 1'b1, c[0], 9'(c), $urandom);
            tick(1);
        end
        phase = 0;
        clear_all();
        tick(3);
        // Lone requester: counter wraps, grant never drops
        do_reset();
        for (int c = 0; c < 40; c++) begin
            set_req(REQ_HOST_READ, 1'b1, 1'b0, 9'(c + 20), 32'h0);
            tick(1);
        end
        clear_all();
        tick(3);
        // Write 511 by requester 1, then read it back through requester 2
        set_req(REQ_MATMUL, 1'b1, 1'b1, 9'd511, 32'h12345678);
        tick(2);
        clear_all();
        set_req(REQ_HOST_READ, 1'b1, 1'b0, 9'd511, 32'h0);
        tick(2);
        clear_all();
        tick(2);
        phase = 2;
        tick(1);
        phase = 0;
        // Reset the cycle after an accepted read
        do_reset();
        set_req(REQ_HOST_LOAD, 1'b1, 1'b0, 9'd7, 32'h0);
        tick(2);
        rst = 1'b0;
        tick(1);
        clear_all();
        rst = 1'b1;
        tick(2);
        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                for (int i = 0; i < N; i++) begin
                    logic on;
                    on = req[i];
                    if ($urandom_range(0, 23) == 0) on = ~on;
                    set_req(i, on, ($urandom_range(0, 2) == 0),
                            ($urandom_range(0, 9) == 0) ? 9'd511 : 9'($urandom_range(0, 15)),
                            $urandom);
                end
                tick(1);
            end
        end
        clear_all();
        tick(4);
        phase = 3;
        tick(1);
        phase = 0;
        tick(1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ram_port_arbiter
